// File: rtl/ifetch_queue_if.sv
// Byte-wide instruction memory request bus between the fetch queue (master)
// and the instruction memory (slave).
interface ifetch_queue_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [7:0]  imem_rdata;

  modport master (output imem_addr, output imem_req, input imem_ack, input imem_rdata);
  modport slave  (input imem_addr, input imem_req, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: assembles 16-bit big-endian instructions from two
// byte reads into a tagged prefetch queue and presents the one matching pc.
//
// state | meaning
// ST_HI | requesting byte at ftag (instr[15:8]); idle while the queue is full
// ST_LO | requesting byte at ftag+1 (instr[7:0]); pushes the entry on ack
module ifetch_queue #(
  parameter int DEPTH  = 2,
  parameter int STRIDE = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   pc,
  input  logic          advance,
  output logic [15:0]   instr,
  output logic          instr_valid,
  ifetch_queue_if.master imem
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {ST_HI, ST_LO} state_e;

  state_e          state_q, state_d;
  logic [15:0]     fpc_q, fpc_d;
  logic [15:0]     ftag_q, ftag_d;
  logic [7:0]      hi_byte_q, hi_byte_d;
  logic [15:0]     tag_q  [DEPTH];
  logic [15:0]     tag_d  [DEPTH];
  logic [15:0]     data_q [DEPTH];
  logic [15:0]     data_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [15:0]     head_tag;
  logic [15:0]     exp_pc;
  logic            redirect;
  logic            full;
  logic            req_int;
  logic            push;
  logic            pop;
  logic [15:0]     fetch_next;

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    ftag_d      = ftag_q;
    hi_byte_d   = hi_byte_q;
    tag_d       = tag_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    push        = 1'b0;
    pop         = 1'b0;
    req_int     = 1'b0;
    imem.imem_addr = ftag_q;

    head_tag    = tag_q[head_q];
    full        = (count_q == CW'(DEPTH));
    exp_pc      = (count_q != '0) ? head_tag : ftag_q;
    redirect    = (pc != exp_pc);
    instr_valid = (count_q != '0) && (head_tag == pc);
    instr       = instr_valid ? data_q[head_q] : 16'h0000;
    // fpc and ftag always move together; fpc is the base for the next fetch
    fetch_next  = fpc_q + 16'(STRIDE);

    case (state_q)
      ST_HI: begin
        imem.imem_addr = ftag_q;
        req_int        = !full;
      end
      ST_LO: begin
        imem.imem_addr = ftag_q + 16'd1;
        req_int        = 1'b1;
      end
      default: begin
        imem.imem_addr = ftag_q;
        req_int        = 1'b0;
      end
    endcase
    // Request is held off while reset is asserted even though the FSM rests in HI
    imem.imem_req = reset && req_int;

    if (redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      ftag_d  = pc;
      fpc_d   = pc;
      state_d = ST_HI;
    end else begin
      pop = advance && instr_valid;
      case (state_q)
        ST_HI: begin
          if (req_int && imem.imem_ack) begin
            hi_byte_d = imem.imem_rdata;
            state_d   = ST_LO;
          end
        end
        ST_LO: begin
          if (imem.imem_ack) begin
            push           = 1'b1;
            tag_d[tail_q]  = ftag_q;
            data_d[tail_q] = {hi_byte_q, imem.imem_rdata};
            tail_d         = tail_q + PW'(1);
            ftag_d         = fetch_next;
            fpc_d          = fetch_next;
            state_d        = ST_HI;
          end
        end
        default: state_d = ST_HI;
      endcase
      if (pop) head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HI;
      fpc_q     <= '0;
      ftag_q    <= '0;
      hi_byte_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      ftag_q    <= ftag_d;
      hi_byte_q <= hi_byte_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: cycle tables for streaming, redirect, full
// queue and wrap, plus hand sequences for startup, wait states and async reset.
module tb_ifetch_queue;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic        advance;
  logic [15:0] instr;
  logic        instr_valid;
  logic        startup_mode;
  logic        wait_mode;
  int          wcnt;

  int checks;
  int failures;
  int lo_acks;
  logic        prev_pending;
  logic [15:0] prev_addr;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(2), .STRIDE(2)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .pc          (pc),
    .advance     (advance),
    .instr       (instr),
    .instr_valid (instr_valid),
    .imem        (bus.master)
  );

  // Memory: byte = low address byte, except bytes 0/1 during the startup test
  assign bus.imem_rdata = (startup_mode && bus.imem_addr == 16'h0000) ? 8'h12 :
                          (startup_mode && bus.imem_addr == 16'h0001) ? 8'h34 :
                          bus.imem_addr[7:0];
  assign bus.imem_ack   = bus.imem_req && (!wait_mode || wcnt == 3);

  always @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else                               wcnt <= 0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        adv;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      if (prev_pending && bus.imem_req)
        chk("addr_stable", bus.imem_addr, prev_addr);
      if (bus.imem_req && bus.imem_ack && bus.imem_addr[0]) lo_acks++;
      prev_pending = bus.imem_req && !bus.imem_ack;
      prev_addr    = bus.imem_addr;
    end
  endtask

  initial begin
    checks = 0; failures = 0; lo_acks = 0;
    prev_pending = 1'b0; prev_addr = '0;
    wcnt = 0;
    rst_n = 1'b0; pc = '0; advance = 1'b0;
    startup_mode = 1'b1; wait_mode = 1'b0;

    //            pc        adv   req   addr      valid instr
    tbl[0]  = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000};
    tbl[2]  = '{16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0001};
    tbl[3]  = '{16'h0002, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000};
    tbl[4]  = '{16'h0002, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0203};
    tbl[5]  = '{16'h0040, 1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000};
    tbl[6]  = '{16'h0040, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000};
    tbl[7]  = '{16'h0040, 1'b0, 1'b1, 16'h0041, 1'b0, 16'h0000};
    tbl[8]  = '{16'h0040, 1'b0, 1'b1, 16'h0042, 1'b1, 16'h4041};
    tbl[9]  = '{16'h0040, 1'b0, 1'b1, 16'h0043, 1'b1, 16'h4041};
    tbl[10] = '{16'h0040, 1'b0, 1'b0, 16'h0044, 1'b1, 16'h4041};
    tbl[11] = '{16'h0040, 1'b0, 1'b0, 16'h0044, 1'b1, 16'h4041};
    tbl[12] = '{16'h0040, 1'b1, 1'b0, 16'h0044, 1'b1, 16'h4041};
    tbl[13] = '{16'h0042, 1'b0, 1'b1, 16'h0044, 1'b1, 16'h4243};
    tbl[14] = '{16'h0042, 1'b0, 1'b1, 16'h0045, 1'b1, 16'h4243};
    tbl[15] = '{16'h0042, 1'b0, 1'b0, 16'h0046, 1'b1, 16'h4243};
    tbl[16] = '{16'hFFFF, 1'b0, 1'b0, 16'h0046, 1'b0, 16'h0000};
    tbl[17] = '{16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000};
    tbl[18] = '{16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[19] = '{16'hFFFF, 1'b0, 1'b1, 16'h0001, 1'b1, 16'hFF00};

    // Reset state and startup
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   {15'd0, bus.imem_req}, 16'h0000);
    chk("rst_addr",  bus.imem_addr, 16'h0000);
    chk("rst_valid", {15'd0, instr_valid}, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("start_req0",  {15'd0, bus.imem_req}, 16'h0001);
    chk("start_addr0", bus.imem_addr, 16'h0000);
    @(negedge clk); #1;
    chk("start_req1",  {15'd0, bus.imem_req}, 16'h0001);
    chk("start_addr1", bus.imem_addr, 16'h0001);
    @(negedge clk); #1;
    chk("start_valid", {15'd0, instr_valid}, 16'h0001);
    chk("start_instr", instr, 16'h1234);

    // Table: stream, redirect mid-LO, full queue, wrap-around
    rst_n = 1'b0;
    startup_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      pc      = tbl[i].pc;
      advance = tbl[i].adv;
      #1;
      chk($sformatf("v%0d_req", i),   {15'd0, bus.imem_req}, {15'd0, tbl[i].req});
      chk($sformatf("v%0d_addr", i),  bus.imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), {15'd0, instr_valid}, {15'd0, tbl[i].valid});
      chk($sformatf("v%0d_instr", i), instr, tbl[i].instr);
    end

    // Wait states with queue filling up, then one advance
    @(negedge clk);
    rst_n = 1'b0; advance = 1'b0; pc = 16'h0000; wait_mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    lo_acks = 0; prev_pending = 1'b0;
    run_cycles(30);
    chk("wait_fills",     lo_acks[15:0], 16'd2);
    chk("wait_full_req",  {15'd0, bus.imem_req}, 16'h0000);
    chk("wait_valid",     {15'd0, instr_valid}, 16'h0001);
    chk("wait_instr",     instr, 16'h0001);
    advance = 1'b1;
    @(posedge clk);
    #1;
    advance = 1'b0;
    pc = 16'h0002;
    lo_acks = 0; prev_pending = 1'b0;
    run_cycles(30);
    chk("resume_fills",   lo_acks[15:0], 16'd1);
    chk("resume_req",     {15'd0, bus.imem_req}, 16'h0000);
    chk("resume_instr",   instr, 16'h0203);

    // Async reset between edges with two entries queued
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {15'd0, instr_valid}, 16'h0000);
    chk("areset_req",   {15'd0, bus.imem_req}, 16'h0000);
    chk("areset_instr", instr, 16'h0000);
    chk("areset_addr",  bus.imem_addr, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
